wb_bram_slave: RTL and testbench
================================

WB_BRAM_SLAVE -- requirements
Module: wb_bram_slave

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL be 8, 16, 32 or 64.
REQ-002 Parameter AW, default 32, Wishbone byte-address width.
REQ-003 Parameter DEPTH, default 512, number of DW-bit words stored; range 2..4096, not necessarily a power of 2.
REQ-004 Parameter WAIT_CYC, default 0, extra wait states inserted before the response; range 0..15.
REQ-005 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 wbs_cyc_i  in  1  bus cycle valid.
REQ-008 wbs_stb_i  in  1  transfer strobe.
REQ-009 wbs_adr_i  in  AW  byte address.
REQ-010 wbs_we_i  in  1  1 = write, 0 = read.
REQ-011 wbs_dat_i  in  DW  write data.
REQ-012 wbs_sel_i  in  DW/8  byte enables, bit n covers wbs_dat_i[8n+7:8n].
REQ-013 wbs_dat_o  out  DW  read data.
REQ-014 wbs_ack_o  out  1  normal termination, one-cycle pulse.
REQ-015 wbs_err_o  out  1  error termination, one-cycle pulse.

Function
REQ-016 Word index SHALL be wbs_adr_i[AW-1:log2(DW/8)]; the low log2(DW/8) address bits SHALL be ignored.
REQ-017 FSM states: IDLE, WAIT, RESP.
- IDLE->WAIT when cyc&stb and WAIT_CYC>0.
- IDLE->RESP when cyc&stb and WAIT_CYC=0.
- WAIT->RESP after WAIT_CYC cycles in WAIT.
- RESP->IDLE always.
REQ-018 In IDLE, on cyc&stb the block SHALL capture adr, we, dat_i and sel; later changes to these inputs SHALL NOT affect the transfer.
REQ-019 Latency: ack or err SHALL be high exactly WAIT_CYC+1 cycles after the edge that samples the request. It SHALL be high for exactly one cycle, in RESP.
REQ-020 Back-to-back: a new request SHALL be accepted no earlier than the cycle after RESP, giving at most one transfer per WAIT_CYC+2 cycles. A strobe still high during RESP SHALL NOT start a new transfer.
REQ-021 Write: on the edge entering RESP, only the bytes whose sel bit is 1 SHALL be updated. With sel=0, no byte SHALL change and the transfer SHALL still be acknowledged.
REQ-022 Read: wbs_dat_o SHALL present the addressed word while ack is high. Otherwise wbs_dat_o SHALL hold its last value. A write SHALL NOT change wbs_dat_o.
REQ-023 Abort: if wbs_cyc_i falls while in WAIT, the FSM SHALL return to IDLE on the next edge with no write, no ack and no err.
REQ-024 ack and err SHALL never be high together.
REQ-025 Word index >= DEPTH is out of range; its handling is given in REQ-030 and REQ-031.

Reset
REQ-026 While rst_n=0:
- state = IDLE;
- wbs_ack_o = 0;
- wbs_err_o = 0;
- wbs_dat_o = 0;
- wait counter = 0.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer: no write, and no ack or err after release.
REQ-029 The first request SHALL be accepted on the first edge after rst_n rises.

Configuration
REQ-030 With macro WB_BRAM_RANGE_ERR_EN defined, an out-of-range access SHALL pulse wbs_err_o at the ack timing of REQ-019. It SHALL perform no write and leave wbs_dat_o unchanged.
REQ-031 Without WB_BRAM_RANGE_ERR_EN:
- wbs_err_o SHALL be constant 0;
- the word index SHALL be reduced modulo DEPTH;
- the access SHALL complete with ack as normal.

Verification
REQ-032 DW=32, WAIT_CYC=0: write 0xDEADBEEF to 0x10 with sel=0xF, then read 0x10 -> each ack one cycle after request; read data 0xDEADBEEF.
REQ-033 Preload 0x11223344 at word 4, then write 0xAABBCCDD to 0x10 with sel=0x5, then read -> 0x11BB33DD.
REQ-034 WAIT_CYC=3: read request at cycle t -> ack only at cycle t+4. Drop cyc at t+2 -> no ack and memory unchanged.
REQ-035 DEPTH=500, word 500 accessed -> with WB_BRAM_RANGE_ERR_EN: err pulse, no ack, no write. Without it: ack, and word 0 is accessed.
REQ-036 rst_n low at cycle t+1 of a WAIT_CYC=3 write -> outputs 0 asynchronously, no ack after release, target word unchanged, next request served normally.

Source files
------------

// File: rtl/wb_bram_slave.sv
// wb_bram_slave: Wishbone slave over a byte-enabled word RAM with WAIT_CYC wait states.
// Define WB_BRAM_RANGE_ERR_EN to terminate out-of-range accesses with err instead of wrapping modulo DEPTH.
module wb_bram_slave #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int DEPTH    = 512,
    parameter int WAIT_CYC = 0
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic [AW-1:0]   wbs_adr_i,
    input  logic            wbs_we_i,
    input  logic [DW-1:0]   wbs_dat_i,
    input  logic [DW/8-1:0] wbs_sel_i,
    output logic [DW-1:0]   wbs_dat_o,
    output logic            wbs_ack_o,
    output logic            wbs_err_o
);
    localparam int OFF = $clog2(DW/8);
    localparam int IW  = AW - OFF;
    localparam int MW  = $clog2(DEPTH);
    localparam int SW  = DW/8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, next_state;
    logic [3:0]      cnt;
    logic [AW-1:0]   adr_q;
    logic            we_q;
    logic [DW-1:0]   dat_q;
    logic [SW-1:0]   sel_q;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   cur_adr;
    logic            cur_we;
    logic [DW-1:0]   cur_dat;
    logic [SW-1:0]   cur_sel;
    logic [IW-1:0]   idx;
    logic [MW-1:0]   widx;
    logic            req, oor, go, wr, rd;

    assign req = wbs_cyc_i & wbs_stb_i;

    // With no wait states the access completes on the sampling edge, so the live bus is used in IDLE.
    assign cur_adr = (state == IDLE) ? wbs_adr_i : adr_q;
    assign cur_we  = (state == IDLE) ? wbs_we_i  : we_q;
    assign cur_dat = (state == IDLE) ? wbs_dat_i : dat_q;
    assign cur_sel = (state == IDLE) ? wbs_sel_i : sel_q;
    assign idx     = IW'(cur_adr >> OFF);

`ifdef WB_BRAM_RANGE_ERR_EN
    assign oor  = idx >= IW'(DEPTH);
    assign widx = MW'(idx);
`else
    assign oor  = 1'b0;
    assign widx = MW'(idx % IW'(DEPTH));
`endif

    assign go = (next_state == RESP) & rst_n;
    assign wr = go & cur_we & ~oor;
    assign rd = go & ~cur_we & ~oor;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= (state == WAIT && next_state == WAIT) ? cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = (WAIT_CYC > 0) ? WAIT : RESP;
            WAIT:    next_state = !wbs_cyc_i ? IDLE : (cnt == 4'(WAIT_CYC - 1)) ? RESP : WAIT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = (state == RESP) & ~oor;
`ifdef WB_BRAM_RANGE_ERR_EN
        wbs_err_o = (state == RESP) & oor;
`else
        wbs_err_o = 1'b0;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (state == IDLE && req) begin
            adr_q <= wbs_adr_i;
            we_q  <= wbs_we_i;
            dat_q <= wbs_dat_i;
            sel_q <= wbs_sel_i;
        end
        if (wr)
            for (int b = 0; b < SW; b++)
                if (cur_sel[b]) mem[widx][8*b +: 8] <= cur_dat[8*b +: 8];
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            wbs_dat_o <= '0;
        else if (rd)
            wbs_dat_o <= mem[widx];
    end
endmodule

// File: tb/tb_wb_bram_slave.sv
// tb_wb_bram_slave: checks wb_bram_slave with zero and three wait states against an array model.
// Expectations follow WB_BRAM_RANGE_ERR_EN when the bench is built with it.
module tb_wb_bram_slave;
    localparam int DEPTH = 500;
    localparam bit RE =
`ifdef WB_BRAM_RANGE_ERR_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        int          d;
        logic [31:0] a;
        logic        w;
        logic [31:0] v;
        logic [3:0]  s;
        logic        ea;
        logic        ee;
        logic [31:0] ed;
    } vec_t;

    logic        sys_clk, rst_n, stb, we;
    logic [1:0]  cyc, ack, err;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic [31:0] dat_o [2];
    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_dat [2];
    int          wc [2] = '{0, 3};
    int          n_chk = 0, n_fail = 0;
    vec_t        tv [13];

    wb_bram_slave #(.DW(32), .AW(32), .DEPTH(DEPTH), .WAIT_CYC(0)) u0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb),
        .wbs_adr_i(adr), .wbs_we_i(we), .wbs_dat_i(dat), .wbs_sel_i(sel),
        .wbs_dat_o(dat_o[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]));

    wb_bram_slave #(.DW(32), .AW(32), .DEPTH(DEPTH), .WAIT_CYC(3)) u1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb),
        .wbs_adr_i(adr), .wbs_we_i(we), .wbs_dat_i(dat), .wbs_sel_i(sel),
        .wbs_dat_o(dat_o[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pre(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5000000;
    endfunction

    always @(negedge sys_clk)
        if (rst_n)
            for (int i = 0; i < 2; i++) chk("ack_err_excl", ack[i] & err[i], 0);

    // Called in the low clock phase; returns in the low phase of the cycle after the response.
    task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] v,
                        input logic [3:0] s, input logic e_ack, input logic e_err, input logic [31:0] e_dat);
        int k;
        bit found;
        int unsigned eff;
        logic [31:0] exp_d;
        exp_d = (!w && e_ack) ? e_dat : last_dat[d];
        adr = a; we = w; dat = v; sel = s; stb = 1'b1; cyc[d] = 1'b1;
        @(posedge sys_clk);
        #1;
        adr = $urandom; we = 1'($urandom); dat = $urandom; sel = 4'($urandom);
        k = 0;
        found = 0;
        while (!found && k < 40) begin
            @(negedge sys_clk);
            if (ack[d] | err[d]) found = 1; else k++;
        end
        chk("resp_seen", found, 1);
        chk("latency", k + 1, wc[d] + 1);
        chk("ack", ack[d], e_ack);
        chk("err", err[d], e_err);
        chk("dat_o", dat_o[d], exp_d);
        cyc[d] = 1'b0; stb = 1'b0;
        if (w && e_ack) begin
            eff = a[31:2] % DEPTH;
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[d][eff][8*b +: 8] = v[8*b +: 8];
        end
        last_dat[d] = exp_d;
        @(negedge sys_clk);
        chk("pulse_end", ack[d] | err[d], 0);
    endtask

    task automatic mxfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] v, input logic [3:0] s);
        int unsigned idx;
        bit o;
        logic [31:0] e;
        idx = a[31:2];
        o = RE && idx >= DEPTH;
        e = (!w && !o) ? mdl[d][idx % DEPTH] : last_dat[d];
        xfer(d, a, w, v, s, !o, o, e);
    endtask

    initial begin
        int unsigned idx;
        bit seen;
        logic [31:0] e;
        tv[0]  = '{0, 32'h10,  1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0};
        tv[1]  = '{0, 32'h10,  1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
        tv[2]  = '{0, 32'h10,  1'b1, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0};
        tv[3]  = '{0, 32'h13,  1'b1, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 32'h0};
        tv[4]  = '{0, 32'h10,  1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h11BB33DD};
        tv[5]  = '{0, 32'h10,  1'b1, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 32'h0};
        tv[6]  = '{0, 32'h11,  1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h11BB33DD};
        tv[7]  = '{0, 32'h7D0, 1'b1, 32'h5A5A5A5A, 4'hF, !RE,  RE,   32'h0};
        tv[8]  = '{0, 32'h0,   1'b0, 32'h0,        4'h0, 1'b1, 1'b0, RE ? pre(0) : 32'h5A5A5A5A};
        tv[9]  = '{0, 32'h7D0, 1'b0, 32'h0,        4'h0, !RE,  RE,   32'h5A5A5A5A};
        tv[10] = '{1, 32'h10,  1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0};
        tv[11] = '{1, 32'h10,  1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
        tv[12] = '{0, 32'h7CC, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, pre(499)};

        rst_n = 1'b0; cyc = '0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
        last_dat[0] = '0; last_dat[1] = '0;
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ack", ack[i], 0);
            chk("rst_err", err[i], 0);
            chk("rst_dat", dat_o[i], 0);
        end
        rst_n = 1'b1;
        // first request presented right at reset release
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) mxfer(d, 32'(i) << 2, 1'b1, pre(i), 4'hF);

        for (int i = 0; i < 13; i++)
            xfer(tv[i].d, tv[i].a, tv[i].w, tv[i].v, tv[i].s, tv[i].ea, tv[i].ee, tv[i].ed);

        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 150; n++) begin
                idx = $urandom_range(0, DEPTH + 49);
                mxfer(d, (idx << 2) | ($urandom & 3), 1'($urandom), $urandom, 4'($urandom));
            end

        // strobe held through RESP must not start a second transfer
        e = mdl[0][3];
        adr = 32'd12; we = 1'b0; stb = 1'b1; cyc[0] = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        chk("hold_ack", ack[0], 1);
        chk("hold_dat", dat_o[0], e);
        @(posedge sys_clk); @(negedge sys_clk);
        chk("hold_no_restart", ack[0] | err[0], 0);
        cyc[0] = 1'b0; stb = 1'b0; last_dat[0] = e;
        @(posedge sys_clk); @(negedge sys_clk);
        chk("hold_idle", ack[0] | err[0], 0);

        // cyc dropped while waiting: no write, no response
        adr = 32'd28; we = 1'b1; dat = 32'hCAFEF00D; sel = 4'hF; stb = 1'b1; cyc[1] = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        @(posedge sys_clk); @(negedge sys_clk);
        cyc[1] = 1'b0; stb = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge sys_clk);
            if (ack[1] | err[1]) seen = 1;
        end
        chk("abort_no_resp", seen, 0);
        chk("abort_dat_hold", dat_o[1], last_dat[1]);
        mxfer(1, 32'd28, 1'b0, 32'h0, 4'h0);

        // reset during a waited write
        adr = 32'd36; we = 1'b1; dat = 32'h0BADBEEF; sel = 4'hF; stb = 1'b1; cyc[1] = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("midrst_ack", ack[i], 0);
            chk("midrst_err", err[i], 0);
            chk("midrst_dat", dat_o[i], 0);
        end
        cyc = '0; stb = 1'b0; last_dat[0] = '0; last_dat[1] = '0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge sys_clk);
            if (ack != 2'b00 || err != 2'b00) seen = 1;
        end
        chk("postrst_no_resp", seen, 0);
        mxfer(1, 32'd36, 1'b0, 32'h0, 4'h0);
        mxfer(0, 32'd36, 1'b0, 32'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
